muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative HI/LO multiply/divide unit (radix-2 shift-add multiply,
//            restoring divide). Divide logic built only when MULDIV_UNIT_DIV_EN
//            is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]    OP_MTHI  = 3'b100;
    localparam logic [2:0]    OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_q;
    logic               done_q;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_mul_op;
    logic               w_pend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_UNIT_DIV_EN
    logic               is_div_q;
    logic               neg_rem_q;
    logic               dbz_q;
    logic               dbz_pend_q;
    logic               w_div_op;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
`endif

    // op[0] selects the signed variant for both MULT and DIV.
    assign w_signed = op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_mul_op = (op[2:1] == 2'b00);

`ifdef MULDIV_UNIT_DIV_EN
    assign w_div_op = (op[2:1] == 2'b01);
    assign w_pend   = dbz_pend_q;
`else
    assign w_pend   = 1'b0;
`endif

    // One iteration: acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide.
    always_comb begin
        w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_d     = {w_mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_UNIT_DIV_EN
        w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        w_trial   = w_rem_sh - {1'b0, opb_q};
        if (is_div_q) begin
            if (w_rem_sh >= {1'b0, opb_q}) begin
                acc_d = {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        w_prod   = neg_q ? -acc_d : acc_d;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
`ifdef MULDIV_UNIT_DIV_EN
        // Remainder follows the dividend's sign; most-negative / -1 wraps back.
        if (is_div_q) begin
            w_res_lo = neg_q     ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
            w_res_hi = neg_rem_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_UNIT_DIV_EN
            is_div_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
`ifdef MULDIV_UNIT_DIV_EN
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_UNIT_DIV_EN
            dbz_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (w_pend) begin
`ifdef MULDIV_UNIT_DIV_EN
                        done_q     <= 1'b1;
                        dbz_q      <= 1'b1;
                        dbz_pend_q <= 1'b0;
`endif
                    end else if (start) begin
                        if (w_mul_op) begin
                            state_q  <= CALC;
                            cnt_q    <= '0;
                            acc_q    <= {{WIDTH{1'b0}}, w_a_mag};
                            opb_q    <= w_b_mag;
                            neg_q    <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_UNIT_DIV_EN
                            is_div_q <= 1'b0;
`endif
                        end
`ifdef MULDIV_UNIT_DIV_EN
                        else if (w_div_op) begin
                            if (b == '0) begin
                                dbz_pend_q <= 1'b1;
                            end else begin
                                state_q   <= CALC;
                                cnt_q     <= '0;
                                acc_q     <= {{WIDTH{1'b0}}, w_a_mag};
                                opb_q     <= w_b_mag;
                                neg_q     <= w_a_neg ^ w_b_neg;
                                neg_rem_q <= w_a_neg;
                                is_div_q  <= 1'b1;
                            end
                        end
`endif
                        else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        hi_q    <= w_res_hi;
                        lo_q    <= w_res_lo;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CALC);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_UNIT_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int lat;
    logic busy_ok;
    logic seen_done;
    logic [31:0] hi_s, lo_s;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);

        // MULTU all-ones
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_latency", lat, 32);
        chk("multu_busy_during", busy_ok, 1);
        chk("multu_busy_after", busy, 0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        tick();
        chk("multu_done_one_cycle", done, 0);

        // MULT -3 * 5
        run_op(3'b001, 32'hFFFFFFFD, 32'd5);
        chk("mult_latency", lat, 32);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        // MTLO then MTHI
        op = 3'b101; a = 32'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h12345678);
        chk("mtlo_hi", hi, 32'hFFFFFFFF);
        chk("mtlo_done", done, 0);
        chk("mtlo_busy", busy, 0);
        op = 3'b100; a = 32'hCAFEF00D; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mthi_hi", hi, 32'hCAFEF00D);
        chk("mthi_lo", lo, 32'h12345678);

        // Flush beats start in the same cycle
        op = 3'b100; a = 32'h0BADBEEF; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_mthi", hi, 32'hCAFEF00D);

        // Reserved op ignored
        op = 3'b110; a = 32'h11111111; b = 32'h2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rsv_busy", busy, 0);
        tick();
        chk("rsv_done", done, 0);
        chk("rsv_hi", hi, 32'hCAFEF00D);
        chk("rsv_lo", lo, 32'h12345678);

`ifdef MULDIV_UNIT_DIV_EN
        run_op(3'b011, 32'hFFFFFFF9, 32'd2);
        chk("div_latency", lat, 32);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
        chk("div_neg_dbz", div_by_zero, 0);
        run_op(3'b011, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);
        chk("div_ovf_dbz", div_by_zero, 0);
        run_op(3'b011, 32'd7, 32'hFFFFFFFE);
        chk("div_negb_lo", lo, 32'hFFFFFFFD);
        chk("div_negb_hi", hi, 32'd1);
        run_op(3'b010, 32'd100, 32'd7);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // Divide by zero: done one edge after sampling, no busy
        op = 3'b010; a = 32'd5; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dbz_busy0", busy, 0);
        chk("dbz_done_early", done, 0);
        tick();
        chk("dbz_done", done, 1);
        chk("dbz_flag", div_by_zero, 1);
        chk("dbz_busy1", busy, 0);
        chk("dbz_hi", hi, 32'd2);
        chk("dbz_lo", lo, 32'd14);
        tick();
        chk("dbz_done_clear", done, 0);
        chk("dbz_flag_clear", div_by_zero, 0);
`else
        hi_s = hi; lo_s = lo;
        seen_done = 1'b0; busy_ok = 1'b1;
        op = 3'b010; a = 32'd5; b = 32'd0; start = 1'b1;
        tick();
        op = 3'b011; a = 32'd7; b = 32'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_ok = 1'b0;
            if (done || div_by_zero) seen_done = 1'b1;
            tick();
        end
        chk("nodiv_busy", busy_ok, 1);
        chk("nodiv_done", seen_done, 0);
        chk("nodiv_hi", hi, hi_s);
        chk("nodiv_lo", lo, lo_s);
`endif

        // Ignored second start and flush mid-CALC
        hi_s = hi; lo_s = lo;
        op = 3'b000; a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("flush_busy_mid", busy, 1);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy0", busy, 0);
        seen_done = 1'b0; busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done = 1'b1;
            if (busy) busy_ok = 1'b0;
            tick();
        end
        chk("flush_no_done", seen_done, 0);
        chk("flush_stays_idle", busy_ok, 1);
        chk("flush_hi", hi, hi_s);
        chk("flush_lo", lo, lo_s);

        // Back-to-back: start accepted in the done cycle
        run_op(3'b000, 32'd6, 32'd7);
        chk("b2b_first_lo", lo, 32'd42);
        chk("b2b_first_hi", hi, 32'd0);
        run_op(3'b000, 32'h00010000, 32'h00010000);
        chk("b2b_second_latency", lat, 32);
        chk("b2b_second_busy", busy_ok, 1);
        chk("b2b_second_hi", hi, 32'd1);
        chk("b2b_second_lo", lo, 32'd0);

        // Reset mid-operation, then a fresh multiply
`ifdef MULDIV_UNIT_DIV_EN
        op = 3'b011;
`else
        op = 3'b000;
`endif
        a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_dbz", div_by_zero, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        run_op(3'b000, 32'd2, 32'd3);
        chk("post_rst_latency", lat, 32);
        chk("post_rst_lo", lo, 32'd6);
        chk("post_rst_hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
